// File: rtl/uop_pkg.sv
// uop_pkg: shared micro-op definitions and queue sizing constants used by the
// decode -> dispatch instruction queue.
//   uop_insn        packed decoded micro-op carried through the queue
//   INSTR_Q_DEPTH   number of queue entries
//   INSTR_Q_WIDTH   maximum uops accepted from decode per cycle
//   DISPATCH_WIDTH  maximum uops handed to dispatch per cycle
package uop_pkg;

  localparam int INSTR_Q_DEPTH  = 16;
  localparam int INSTR_Q_WIDTH  = 2;
  localparam int DISPATCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } uop_insn;

endpackage

// File: rtl/iq_storage.sv
// iq_storage: register array backing the instruction queue.
//   clk_in   clock
//   wr_en    per-port write enable (WR_PORTS ports)
//   wr_idx   per-port write slot, always < DEPTH
//   wr_data  per-port write data
//   rd_idx   per-port read slot (RD_PORTS ports), always < DEPTH
//   rd_data  combinational read data
// Write ports must target distinct slots in any one cycle.
module iq_storage
  import uop_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int PTR_W    = 4
) (
  input  logic             clk_in,
  input  logic             wr_en   [WR_PORTS],
  input  logic [PTR_W-1:0] wr_idx  [WR_PORTS],
  input  uop_insn          wr_data [WR_PORTS],
  input  logic [PTR_W-1:0] rd_idx  [RD_PORTS],
  output uop_insn          rd_data [RD_PORTS]
);

  uop_insn mem [DEPTH];

  // Data array carries no reset; validity is tracked by the controller.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx[i]] <= wr_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i] = mem[rd_idx[i]];
    end
  end

endmodule

// File: rtl/instr_queue_ctrl.sv
// instr_queue_ctrl: circular instruction queue between decode and dispatch.
//   clk_in            clock
//   rst_N_in          synchronous active-high reset
//   flush_in          discard all queued entries (error flags kept)
//   push_count_in     number of valid push slots, packed from slot 0
//   push_insn_in      uops to enqueue; slot 0 is oldest
//   ready_out         a full INSTR_Q_WIDTH group can be accepted this cycle
//   pop_count_in      number of head entries dispatch consumes this cycle
//   out_valid_count   number of valid entries on out_insn
//   out_insn          oldest entries; slot 0 is the head
//   occupancy_out     current entry count
//   overflow_err_out  sticky: push presented while ready_out was low
//   underflow_err_out sticky: pop_count_in exceeded out_valid_count
module instr_queue_ctrl #(
  parameter int INSTR_Q_DEPTH  = uop_pkg::INSTR_Q_DEPTH,
  parameter int INSTR_Q_WIDTH  = uop_pkg::INSTR_Q_WIDTH,
  parameter int DISPATCH_WIDTH = uop_pkg::DISPATCH_WIDTH
) (
  input  logic                                  clk_in,
  input  logic                                  rst_N_in,
  input  logic                                  flush_in,
  input  logic [$clog2(INSTR_Q_WIDTH+1)-1:0]    push_count_in,
  input  uop_pkg::uop_insn                      push_insn_in [INSTR_Q_WIDTH],
  output logic                                  ready_out,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   pop_count_in,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0]   out_valid_count,
  output uop_pkg::uop_insn                      out_insn [DISPATCH_WIDTH],
  output logic [$clog2(INSTR_Q_DEPTH+1)-1:0]    occupancy_out,
  output logic                                  overflow_err_out,
  output logic                                  underflow_err_out
);

  localparam int PTR_W = (INSTR_Q_DEPTH > 1) ? $clog2(INSTR_Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(INSTR_Q_DEPTH + 1);
  localparam int PSH_W = $clog2(INSTR_Q_WIDTH + 1);
  localparam int POP_W = $clog2(DISPATCH_WIDTH + 1);

  localparam logic [PTR_W:0]   DEPTH_W   = (PTR_W+1)'(INSTR_Q_DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(INSTR_Q_DEPTH - INSTR_Q_WIDTH);
  localparam logic [CNT_W-1:0] DISP_CNT  = CNT_W'(DISPATCH_WIDTH);

  // Modular pointer add by compare-and-subtract so non power-of-two depths
  // never index past DEPTH-1. base < DEPTH and off <= DEPTH, so one subtract
  // is always enough.
  function automatic logic [PTR_W-1:0] mod_add(input logic [PTR_W-1:0] base,
                                               input logic [PTR_W:0]   off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= DEPTH_W) begin
      sum = sum - DEPTH_W;
    end
    return sum[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             unf_q;

  logic [PSH_W-1:0] acc_push;
  logic [POP_W-1:0] valid_cnt;
  logic [POP_W-1:0] eff_pop;

  logic             wr_en  [INSTR_Q_WIDTH];
  logic [PTR_W-1:0] wr_idx [INSTR_Q_WIDTH];
  logic [PTR_W-1:0] rd_idx [DISPATCH_WIDTH];

  // Ready and output view depend on registered state only, so decode and
  // dispatch never see a combinational path through each other's counts.
  always_comb begin
    ready_out = (count_q <= READY_MAX);
    valid_cnt = (count_q < DISP_CNT) ? POP_W'(count_q) : POP_W'(DISPATCH_WIDTH);
    eff_pop   = (pop_count_in > valid_cnt) ? valid_cnt : pop_count_in;
    acc_push  = ready_out ? push_count_in : '0;
  end

  always_comb begin
    for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
      wr_en[i]  = ready_out && !flush_in && (PSH_W'(i) < push_count_in);
      wr_idx[i] = mod_add(tail_q, (PTR_W+1)'(i));
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rd_idx[i] = mod_add(head_q, (PTR_W+1)'(i));
    end
  end

  // Reset beats flush, flush beats push/pop. Flush keeps the sticky errors.
  always_ff @(posedge clk_in) begin
    if (rst_N_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= mod_add(head_q, (PTR_W+1)'(eff_pop));
      tail_q  <= mod_add(tail_q, (PTR_W+1)'(acc_push));
      count_q <= count_q + CNT_W'(acc_push) - CNT_W'(eff_pop);
      if (!ready_out && (push_count_in != '0)) begin
        ovf_q <= 1'b1;
      end
      if (pop_count_in > valid_cnt) begin
        unf_q <= 1'b1;
      end
    end
  end

  iq_storage #(
    .DEPTH    (INSTR_Q_DEPTH),
    .WR_PORTS (INSTR_Q_WIDTH),
    .RD_PORTS (DISPATCH_WIDTH),
    .PTR_W    (PTR_W)
  ) u_storage (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (push_insn_in),
    .rd_idx  (rd_idx),
    .rd_data (out_insn)
  );

  assign out_valid_count   = valid_cnt;
  assign occupancy_out     = count_q;
  assign overflow_err_out  = ovf_q;
  assign underflow_err_out = unf_q;

endmodule
